// File: rtl/vsync_timing_decoder_pkg.sv
// Shared types for the vertical timing decoder: FSM states, line classes and
// the line classifier.
package vsync_timing_decoder_pkg;

  localparam int W_DEFAULT = 10;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    SYNC      = 3'd1,
    BACK      = 3'd2,
    ACTIVE    = 3'd3,
    FRONT     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_SYNC  = 2'd0,
    CLS_ACT   = 2'd1,
    CLS_PORCH = 2'd2
  } cls_e;

  // A sync line wins over an active flag; anything else is porch.
  function automatic cls_e classify_line(input logic vs, input logic act, input logic pol);
    if (vs == pol) return CLS_SYNC;
    if (act)       return CLS_ACT;
    return CLS_PORCH;
  endfunction

endpackage

// File: rtl/vtiming_lock_check.sv
// Compares each published frame geometry against the previous one and raises
// locked after LOCK_FRAMES consecutive identical frames.
module vtiming_lock_check
  #(parameter int W           = 10,
    parameter int LOCK_FRAMES = 2)
  (input  logic         clock,
   input  logic         reset,
   input  logic         publish,
   input  logic         clear,
   input  logic [W-1:0] in_sync,
   input  logic [W-1:0] in_back,
   input  logic [W-1:0] in_active,
   input  logic [W-1:0] in_front,
   output logic         locked);

  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LF_C = CW'(LOCK_FRAMES);

  logic [W-1:0]  prev_sync_q, prev_sync_d;
  logic [W-1:0]  prev_back_q, prev_back_d;
  logic [W-1:0]  prev_active_q, prev_active_d;
  logic [W-1:0]  prev_front_q, prev_front_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;
  logic          locked_q, locked_d;
  logic          same;

  assign same = (in_sync == prev_sync_q) && (in_back == prev_back_q) &&
                (in_active == prev_active_q) && (in_front == prev_front_q);

  always_comb begin
    prev_sync_d   = prev_sync_q;
    prev_back_d   = prev_back_q;
    prev_active_d = prev_active_q;
    prev_front_d  = prev_front_q;
    match_cnt_d   = match_cnt_q;
    locked_d      = locked_q;
    if (clear) begin
      match_cnt_d = '0;
      locked_d    = 1'b0;
    end else if (publish) begin
      prev_sync_d   = in_sync;
      prev_back_d   = in_back;
      prev_active_d = in_active;
      prev_front_d  = in_front;
      // match_cnt of zero marks "no reference frame yet"
      if (match_cnt_q == '0 || !same)
        match_cnt_d = CW'(1);
      else if (match_cnt_q < LF_C)
        match_cnt_d = match_cnt_q + CW'(1);
      locked_d = (match_cnt_d >= LF_C);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_sync_q   <= '0;
      prev_back_q   <= '0;
      prev_active_q <= '0;
      prev_front_q  <= '0;
      match_cnt_q   <= '0;
      locked_q      <= 1'b0;
    end else begin
      prev_sync_q   <= prev_sync_d;
      prev_back_q   <= prev_back_d;
      prev_active_q <= prev_active_d;
      prev_front_q  <= prev_front_d;
      match_cnt_q   <= match_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/vsync_timing_decoder.sv
// Recovers vertical timing (sync, back porch, active, front porch) in lines
// from a line strobe, vsync level and per-line active flag.
//
//   state     | meaning
//   WAIT_SYNC | idle until a fresh sync leading edge (partial pulses ignored)
//   SYNC      | counting sync lines
//   BACK      | counting back-porch lines
//   ACTIVE    | counting active lines, yposition tracks them
//   FRONT     | counting front-porch lines until the next sync closes the frame
module vsync_timing_decoder
  import vsync_timing_decoder_pkg::*;
  #(parameter int W           = W_DEFAULT,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2)
  (input  logic         clock,
   input  logic         reset,
   input  logic         LineEnd,
   input  logic         vsync,
   input  logic         LineActive,
   output logic [W-1:0] SynchPulse,
   output logic [W-1:0] BackPorch,
   output logic [W-1:0] ActiveVideo,
   output logic [W-1:0] FrontPorch,
   output logic [W-1:0] yposition,
   output logic         frame_done,
   output logic         locked,
   output logic         sync_error);

  state_e       state_q, state_d;
  logic         lineend_q, lineend_d;
  logic         prev_sync_q, prev_sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ypos_q, ypos_d;
  logic [W-1:0] hold_sync_q, hold_sync_d;
  logic [W-1:0] hold_back_q, hold_back_d;
  logic [W-1:0] hold_active_q, hold_active_d;
  logic [W-1:0] hold_front_q, hold_front_d;
  logic [W-1:0] out_sync_q, out_sync_d;
  logic [W-1:0] out_back_q, out_back_d;
  logic [W-1:0] out_active_q, out_active_d;
  logic [W-1:0] out_front_q, out_front_d;
  logic         publish_q, publish_d;
  logic         frame_done_q, frame_done_d;
  logic         sync_error_q, sync_error_d;

  logic         line_evt;
  logic         cnt_max;
  logic         err;
  logic         complete;
  cls_e         cls;

  assign line_evt = LineEnd & ~lineend_q;
  assign cls      = classify_line(vsync, LineActive, SYNC_POL);
  assign cnt_max  = (cnt_q == {W{1'b1}});

  always_comb begin
    state_d       = state_q;
    lineend_d     = LineEnd;
    prev_sync_d   = prev_sync_q;
    cnt_d         = cnt_q;
    ypos_d        = ypos_q;
    hold_sync_d   = hold_sync_q;
    hold_back_d   = hold_back_q;
    hold_active_d = hold_active_q;
    hold_front_d  = hold_front_q;
    out_sync_d    = out_sync_q;
    out_back_d    = out_back_q;
    out_active_d  = out_active_q;
    out_front_d   = out_front_q;
    publish_d     = 1'b0;
    frame_done_d  = 1'b0;
    sync_error_d  = 1'b0;
    err           = 1'b0;
    complete      = 1'b0;

    if (line_evt) begin
      prev_sync_d = (cls == CLS_SYNC);
      case (state_q)
        WAIT_SYNC: begin
          if (cls == CLS_SYNC && !prev_sync_q) begin
            state_d = SYNC;
            cnt_d   = W'(1);
          end
        end
        SYNC: begin
          case (cls)
            CLS_SYNC: begin
              if (cnt_max) err = 1'b1;
              else         cnt_d = cnt_q + W'(1);
            end
            CLS_PORCH: begin
              hold_sync_d = cnt_q;
              state_d     = BACK;
              cnt_d       = W'(1);
            end
            default: begin
              hold_sync_d = cnt_q;
              hold_back_d = '0;
              state_d     = ACTIVE;
              cnt_d       = W'(1);
              ypos_d      = W'(1);
            end
          endcase
        end
        BACK: begin
          case (cls)
            CLS_PORCH: begin
              if (cnt_max) err = 1'b1;
              else         cnt_d = cnt_q + W'(1);
            end
            CLS_ACT: begin
              hold_back_d = cnt_q;
              state_d     = ACTIVE;
              cnt_d       = W'(1);
              ypos_d      = W'(1);
            end
            default: err = 1'b1;
          endcase
        end
        ACTIVE: begin
          case (cls)
            CLS_ACT: begin
              if (cnt_max) err = 1'b1;
              else begin
                cnt_d  = cnt_q + W'(1);
                ypos_d = ypos_q + W'(1);
              end
            end
            CLS_PORCH: begin
              hold_active_d = cnt_q;
              state_d       = FRONT;
              cnt_d         = W'(1);
            end
            default: begin
              hold_active_d = cnt_q;
              hold_front_d  = '0;
              complete      = 1'b1;
            end
          endcase
        end
        FRONT: begin
          case (cls)
            CLS_PORCH: begin
              if (cnt_max) err = 1'b1;
              else         cnt_d = cnt_q + W'(1);
            end
            CLS_SYNC: begin
              hold_front_d = cnt_q;
              complete     = 1'b1;
            end
            default: err = 1'b1;
          endcase
        end
        default: err = 1'b1;
      endcase

      // The closing sync line is also the first line of the next frame.
      if (complete) begin
        state_d   = SYNC;
        cnt_d     = W'(1);
        ypos_d    = '0;
        publish_d = 1'b1;
      end
      if (err) begin
        state_d      = WAIT_SYNC;
        cnt_d        = '0;
        ypos_d       = '0;
        sync_error_d = 1'b1;
      end
    end

    if (publish_q) begin
      out_sync_d   = hold_sync_q;
      out_back_d   = hold_back_q;
      out_active_d = hold_active_q;
      out_front_d  = hold_front_q;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= WAIT_SYNC;
      lineend_q     <= 1'b0;
      prev_sync_q   <= 1'b1;
      cnt_q         <= '0;
      ypos_q        <= '0;
      hold_sync_q   <= '0;
      hold_back_q   <= '0;
      hold_active_q <= '0;
      hold_front_q  <= '0;
      out_sync_q    <= '0;
      out_back_q    <= '0;
      out_active_q  <= '0;
      out_front_q   <= '0;
      publish_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lineend_q     <= lineend_d;
      prev_sync_q   <= prev_sync_d;
      cnt_q         <= cnt_d;
      ypos_q        <= ypos_d;
      hold_sync_q   <= hold_sync_d;
      hold_back_q   <= hold_back_d;
      hold_active_q <= hold_active_d;
      hold_front_q  <= hold_front_d;
      out_sync_q    <= out_sync_d;
      out_back_q    <= out_back_d;
      out_active_q  <= out_active_d;
      out_front_q   <= out_front_d;
      publish_q     <= publish_d;
      frame_done_q  <= frame_done_d;
      sync_error_q  <= sync_error_d;
    end
  end

  // Lock state updates on the publish edge, so it lands with frame_done.
  vtiming_lock_check #(
    .W           (W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock (
    .clock     (clock),
    .reset     (reset),
    .publish   (publish_q),
    .clear     (err & line_evt),
    .in_sync   (hold_sync_q),
    .in_back   (hold_back_q),
    .in_active (hold_active_q),
    .in_front  (hold_front_q),
    .locked    (locked)
  );

  assign SynchPulse  = out_sync_q;
  assign BackPorch   = out_back_q;
  assign ActiveVideo = out_active_q;
  assign FrontPorch  = out_front_q;
  assign yposition   = ypos_q;
  assign frame_done  = frame_done_q;
  assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vsync_timing_decoder.sv
// Directed bench: line-level stimulus with a frame/error scoreboard checked by
// an independent monitor on frame_done and sync_error.
module tb_vsync_timing_decoder;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         LineEnd = 1'b0;
  logic         vsync = 1'b1;
  logic         LineActive = 1'b0;
  logic [W-1:0] SynchPulse, BackPorch, ActiveVideo, FrontPorch, yposition;
  logic         frame_done, locked, sync_error;

  typedef struct {
    logic [W-1:0] s, b, a, f;
    logic         lk;
  } exp_t;

  exp_t exp_q[$];
  int   err_pending = 0;
  int   nchecks = 0;
  int   nerr = 0;

  vsync_timing_decoder #(.W(W), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .LineEnd     (LineEnd),
    .vsync       (vsync),
    .LineActive  (LineActive),
    .SynchPulse  (SynchPulse),
    .BackPorch   (BackPorch),
    .ActiveVideo (ActiveVideo),
    .FrontPorch  (FrontPorch),
    .yposition   (yposition),
    .frame_done  (frame_done),
    .locked      (locked),
    .sync_error  (sync_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int s, input int b, input int a, input int f, input logic lk);
    exp_t e;
    e.s = W'(s); e.b = W'(b); e.a = W'(a); e.f = W'(f); e.lk = lk;
    exp_q.push_back(e);
  endtask

  // One line: strobe high 6 clocks, low 6 clocks; vsync active-low.
  task automatic send_line(input logic is_sync, input logic act, input logic chk_y, input int exp_y);
    @(negedge clock);
    vsync      = ~is_sync;
    LineActive = act;
    LineEnd    = 1'b1;
    repeat (6) @(negedge clock);
    if (chk_y) check("yposition", yposition, exp_y);
    LineEnd = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic send_lines(input int n, input logic is_sync, input logic act);
    for (int i = 0; i < n; i++) send_line(is_sync, act, 1'b0, 0);
  endtask

  task automatic send_frame(input int s, input int b, input int a, input int f, input logic chk_y);
    for (int i = 0; i < s; i++) send_line(1'b1, 1'b0, chk_y, 0);
    for (int i = 0; i < b; i++) send_line(1'b0, 1'b0, chk_y, 0);
    for (int i = 1; i <= a; i++) send_line(1'b0, 1'b1, chk_y, i);
    for (int i = 0; i < f; i++) send_line(1'b0, 1'b0, chk_y, a);
  endtask

  task automatic check_outputs(input string tag, input int s, input int b, input int a, input int f,
                               input logic lk);
    check({tag, " geometry"}, {SynchPulse, BackPorch, ActiveVideo, FrontPorch},
          {W'(s), W'(b), W'(a), W'(f)});
    check({tag, " locked"}, locked, lk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (frame_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected frame_done", frame_done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("frame geometry", {SynchPulse, BackPorch, ActiveVideo, FrontPorch},
                {e.s, e.b, e.a, e.f});
          check("frame locked", locked, e.lk);
        end
      end
      if (sync_error === 1'b1) begin
        if (err_pending == 0) begin
          check("unexpected sync_error", sync_error, 1'b0);
        end else begin
          err_pending--;
          check("locked at sync_error", locked, 1'b0);
          check("frame_done at sync_error", frame_done, 1'b0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchecks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clock);
    check_outputs("reset", 0, 0, 0, 0, 1'b0);
    check("reset yposition", yposition, 0);
    check("reset frame_done", frame_done, 1'b0);
    check("reset sync_error", sync_error, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // First frame's sync arrives with prev_sync=1 and is discarded.
    send_frame(2, 3, 5, 2, 1'b0);
    check("discarded frame yposition", yposition, 0);
    send_frame(2, 3, 5, 2, 1'b1);
    expect_frame(2, 3, 5, 2, 1'b0);
    send_frame(2, 3, 5, 2, 1'b1);
    expect_frame(2, 3, 5, 2, 1'b1);
    send_frame(2, 3, 6, 2, 1'b0);
    expect_frame(2, 3, 6, 2, 1'b0);
    send_frame(2, 3, 6, 2, 1'b0);
    expect_frame(2, 3, 6, 2, 1'b1);
    send_frame(2, 3, 5, 2, 1'b0);
    expect_frame(2, 3, 5, 2, 1'b0);
    send_frame(2, 3, 5, 2, 1'b0);

    // Sync reasserted after one back-porch line.
    expect_frame(2, 3, 5, 2, 1'b1);
    send_lines(2, 1'b1, 1'b0);
    send_lines(1, 1'b0, 1'b0);
    err_pending++;
    send_lines(2, 1'b1, 1'b0);
    check_outputs("after error", 2, 3, 5, 2, 1'b0);
    check("after error yposition", yposition, 0);
    send_lines(3, 1'b0, 1'b0);
    send_lines(5, 1'b0, 1'b1);
    send_lines(2, 1'b0, 1'b0);
    send_frame(2, 3, 5, 2, 1'b0);
    expect_frame(2, 3, 5, 2, 1'b0);
    send_frame(2, 3, 5, 2, 1'b0);
    expect_frame(2, 3, 5, 2, 1'b1);

    // Zero porches.
    send_frame(3, 0, 4, 0, 1'b0);
    expect_frame(3, 0, 4, 0, 1'b0);
    send_frame(3, 0, 4, 0, 1'b0);
    expect_frame(3, 0, 4, 0, 1'b1);
    send_frame(3, 0, 4, 0, 1'b0);
    expect_frame(3, 0, 4, 0, 1'b1);

    // Reset in the middle of ACTIVE, released during the next sync pulse.
    send_lines(3, 1'b1, 1'b0);
    send_lines(2, 1'b0, 1'b1);
    check("pre-reset yposition", yposition, 2);
    reset = 1'b1;
    @(negedge clock);
    check_outputs("mid-frame reset", 0, 0, 0, 0, 1'b0);
    check("mid-frame reset yposition", yposition, 0);
    send_lines(2, 1'b0, 1'b1);
    send_lines(1, 1'b1, 1'b0);
    reset = 1'b0;
    send_lines(2, 1'b1, 1'b0);
    send_lines(3, 1'b0, 1'b0);
    send_lines(5, 1'b0, 1'b1);
    send_lines(2, 1'b0, 1'b0);
    check_outputs("after reset partial", 0, 0, 0, 0, 1'b0);
    send_frame(2, 3, 5, 2, 1'b0);
    expect_frame(2, 3, 5, 2, 1'b0);
    send_frame(2, 3, 5, 2, 1'b0);

    repeat (30) @(negedge clock);
    check("frames left in scoreboard", exp_q.size(), 0);
    check("errors left in scoreboard", err_pending, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
